lpe_frame_sequencer: RTL and testbench



---
 rtl/lpe_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_lpe_frame_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpe_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lpe_frame_sequencer
//
// Feed sequencer for one column of LinearProcessingElements. A raw operand-1
// (weight) stream is framed into the column's up input as fixed-length
// vectors: every data beat is tagged with OP1_USER_MASK and the last beat of
// each vector carries tlast. The data path is a zero-latency combinational
// pass-through that is open only in FEED. After the last beat the block
// counts results exported by the column until every PE has delivered one
// result per vector, then pulses done.
//
// Optional feature (macro LPE_SEQ_RSLT_TIMEOUT_EN): a watchdog on the result
// stream while draining. When it expires the run ends with an err_timeout
// pulse instead of done. Without the macro err_timeout is tied to 0 and the
// drain phase waits indefinitely.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             run request (IDLE only) / synchronous abort
//   cfg_vec_len, cfg_num_vec beats per vector / vectors per run (on start)
//   s_axis_*                 raw operand stream in (tdata, tvalid, tready)
//   m_axis_up_*              framed stream out (tdata, tvalid, tready,
//                            tlast, tuser)
//   rslt_tvalid/tready       monitor of the column's bottom result stream
//   busy                     high while in FEED or DRAIN (registered)
//   done                     one-cycle completion pulse (registered)
//   err_cfg                  one-cycle pulse: start with a zero length
//   err_timeout              one-cycle pulse: result watchdog expired
// ---------------------------------------------------------------------------
module lpe_frame_sequencer #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    USER_WIDTH     = 8,
    parameter int                    PE_NUMBER_J    = 4,
    parameter int                    LEN_WIDTH      = 16,
    parameter logic [USER_WIDTH-1:0] OP1_USER_MASK  = USER_WIDTH'(1) << (USER_WIDTH - 2),
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  cfg_vec_len,
    input  logic [LEN_WIDTH-1:0]  cfg_num_vec,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_up_tdata,
    output logic                  m_axis_up_tvalid,
    input  logic                  m_axis_up_tready,
    output logic                  m_axis_up_tlast,
    output logic [USER_WIDTH-1:0] m_axis_up_tuser,
    input  logic                  rslt_tvalid,
    input  logic                  rslt_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  err_timeout
);

    // Wide enough for num_vec * PE_NUMBER_J plus one spare bit so the count
    // can run past the target (early or surplus results) without wrapping.
    localparam int RC_WIDTH = LEN_WIDTH + $clog2(PE_NUMBER_J) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] vec_len_q, vec_len_d;
    logic [LEN_WIDTH-1:0] num_vec_q, num_vec_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
    logic [RC_WIDTH-1:0]  rslt_cnt_q, rslt_cnt_d;
    logic                 busy_d, done_d, err_cfg_d;

    logic                 feed;
    logic                 is_last;
    logic                 up_hs;
    logic                 rslt_hs;
    logic [RC_WIDTH-1:0]  rslt_sum;
    logic [RC_WIDTH-1:0]  rslt_target;

`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_WIDTH-1:0]  wdog_q, wdog_d;
    logic                 err_timeout_d;
`endif

    // -----------------------------------------------------------------------
    // Framed stream: pure combinational pass-through, gated by FEED.
    // -----------------------------------------------------------------------
    assign feed             = (state_q == S_FEED);
    assign is_last          = (beat_cnt_q == vec_len_q - LEN_WIDTH'(1));
    assign s_axis_tready    = feed && m_axis_up_tready;
    assign m_axis_up_tvalid = feed && s_axis_tvalid;
    assign m_axis_up_tdata  = feed ? s_axis_tdata : '0;
    assign m_axis_up_tuser  = feed ? OP1_USER_MASK : '0;
    assign m_axis_up_tlast  = feed && is_last;

    assign up_hs       = feed && s_axis_tvalid && m_axis_up_tready;
    assign rslt_hs     = ((state_q == S_FEED) || (state_q == S_DRAIN))
                         && rslt_tvalid && rslt_tready;
    // The drain exit compares against the count including this cycle's
    // handshake, so done follows the final result by exactly one cycle.
    assign rslt_sum    = rslt_cnt_q + RC_WIDTH'(rslt_hs);
    assign rslt_target = RC_WIDTH'(num_vec_q) * RC_WIDTH'(PE_NUMBER_J);

    // -----------------------------------------------------------------------
    // Next-state / next-counter logic.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is given a default first; a path
        // that leaves one unassigned would otherwise infer a latch.
        state_d    = state_q;
        vec_len_d  = vec_len_q;
        num_vec_d  = num_vec_q;
        beat_cnt_d = beat_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        rslt_cnt_d = rslt_cnt_q;
        err_cfg_d  = 1'b0;
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
        wdog_d        = wdog_q;
        err_timeout_d = 1'b0;
`endif

        if (abort && (state_q != S_IDLE)) begin
            // Abort outranks everything, including a pending done/timeout.
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            vec_cnt_d  = '0;
            rslt_cnt_d = '0;
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
            wdog_d     = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort has no effect in IDLE but still vetoes a start.
                    if (start && !abort) begin
                        if ((cfg_vec_len != '0) && (cfg_num_vec != '0)) begin
                            state_d    = S_FEED;
                            vec_len_d  = cfg_vec_len;
                            num_vec_d  = cfg_num_vec;
                            beat_cnt_d = '0;
                            vec_cnt_d  = '0;
                            rslt_cnt_d = '0;
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
                            wdog_d     = '0;
`endif
                        end else begin
                            err_cfg_d = 1'b1;
                        end
                    end
                end

                S_FEED: begin
                    if (rslt_hs) begin
                        rslt_cnt_d = rslt_sum;
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
                        wdog_d     = '0;
`endif
                    end
                    if (up_hs) begin
                        if (is_last) begin
                            beat_cnt_d = '0;
                            vec_cnt_d  = vec_cnt_q + LEN_WIDTH'(1);
                            if (vec_cnt_q == num_vec_q - LEN_WIDTH'(1)) begin
                                state_d = S_DRAIN;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    rslt_cnt_d = rslt_sum;
                    if (rslt_sum >= rslt_target) begin
                        state_d = S_DONE;
                    end
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
                    else if (rslt_hs) begin
                        wdog_d = '0;
                    end else if (wdog_q + WD_WIDTH'(1) == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        // The counter reads k-1 in the k-th quiet cycle, so
                        // deciding here lands the registered pulse exactly
                        // TIMEOUT_CYCLES cycles after the last result.
                        state_d       = S_IDLE;
                        err_timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WD_WIDTH'(1);
                    end
`endif
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // -----------------------------------------------------------------------
    // State and counter registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_len_q  <= '0;
            num_vec_q  <= '0;
            beat_cnt_q <= '0;
            vec_cnt_q  <= '0;
            rslt_cnt_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cfg    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed above.
            state_q    <= state_d;
            vec_len_q  <= vec_len_d;
            num_vec_q  <= num_vec_d;
            beat_cnt_q <= beat_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            rslt_cnt_q <= rslt_cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            err_cfg    <= err_cfg_d;
        end
    end

`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wdog_q      <= wdog_d;
            err_timeout <= err_timeout_d;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lpe_frame_sequencer.sv
module tb_lpe_frame_sequencer;

    localparam int DW  = 16;
    localparam int UW  = 8;
    localparam int PE  = 4;
    localparam int LW  = 16;
    localparam int TO  = 16;
    localparam logic [UW-1:0] MASK = 8'h40;  // 1 << (8-2)

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic [LW-1:0] cfg_vec_len, cfg_num_vec;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_up_tdata;
    logic          m_axis_up_tvalid, m_axis_up_tready, m_axis_up_tlast;
    logic [UW-1:0] m_axis_up_tuser;
    logic          rslt_tvalid, rslt_tready;
    logic          busy, done, err_cfg, err_timeout;

    lpe_frame_sequencer #(
        .DATA_WIDTH    (DW),
        .USER_WIDTH    (UW),
        .PE_NUMBER_J   (PE),
        .LEN_WIDTH     (LW),
        .OP1_USER_MASK (MASK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_vec_len     (cfg_vec_len),
        .cfg_num_vec     (cfg_num_vec),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_up_tdata (m_axis_up_tdata),
        .m_axis_up_tvalid(m_axis_up_tvalid),
        .m_axis_up_tready(m_axis_up_tready),
        .m_axis_up_tlast (m_axis_up_tlast),
        .m_axis_up_tuser (m_axis_up_tuser),
        .rslt_tvalid     (rslt_tvalid),
        .rslt_tready     (rslt_tready),
        .busy            (busy),
        .done            (done),
        .err_cfg         (err_cfg),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (run-level view) ----------------
    typedef enum {P_IDLE, P_FEED, P_DRAIN, P_DONE} phase_t;
    phase_t ph;
    int     m_len, m_num;      // captured run geometry
    int     m_beats;           // total beats moved this run
    int     m_rslt;            // results seen this run
    int     quiet_since;       // last cycle with a result or in FEED
    int     cyc;
    bit     exp_busy, exp_done, exp_err_cfg, exp_err_to;

    // ---------------- stimulus knobs ----------------
    int p_valid = 100, p_ready = 100, p_rslt = 50, p_rready = 80;
    bit tog_ready = 1'b0;
    int rslt_cap = 1 << 30;
    bit start_req = 1'b0, abort_req = 1'b0;
    int cfg_len_v = 0, cfg_num_v = 0;

    // ---------------- observations of the DUT ----------------
    int obs_done = 0, obs_err_to = 0, obs_err_cfg = 0, obs_beats = 0;

    int n_vec = 0, n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ph = P_IDLE;
        m_len = 0; m_num = 0; m_beats = 0; m_rslt = 0;
        exp_busy = 0; exp_done = 0; exp_err_cfg = 0; exp_err_to = 0;
    endfunction

    // One clock cycle: drive at negedge, check at negedge+1, then advance
    // the model by what the coming posedge will see.
    task automatic step();
        bit     feed, up_hs, r_hs;
        phase_t nph;
        @(negedge clk);
        s_axis_tvalid    = ($urandom_range(99) < p_valid);
        s_axis_tdata     = DW'($urandom);
        m_axis_up_tready = tog_ready ? !m_axis_up_tready : ($urandom_range(99) < p_ready);
        rslt_tvalid      = (m_rslt < rslt_cap) && ($urandom_range(99) < p_rslt);
        rslt_tready      = ($urandom_range(99) < p_rready);
        start            = start_req;
        abort            = abort_req;
        cfg_vec_len      = LW'(cfg_len_v);
        cfg_num_vec      = LW'(cfg_num_v);
        start_req        = 1'b0;
        abort_req        = 1'b0;
        #1;
        feed = (ph == P_FEED);
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("err_cfg", err_cfg, exp_err_cfg);
        check("err_timeout", err_timeout, exp_err_to);
        check("s_tready", s_axis_tready, feed && m_axis_up_tready);
        check("up_tvalid", m_axis_up_tvalid, feed && s_axis_tvalid);
        check("up_tuser", m_axis_up_tuser, feed ? MASK : 8'h00);
        check("up_tlast", m_axis_up_tlast, feed ? ((m_beats % m_len) == m_len - 1) : 1'b0);
        if (feed && s_axis_tvalid) check("up_tdata", m_axis_up_tdata, s_axis_tdata);

        if (done) obs_done++;
        if (err_timeout) obs_err_to++;
        if (err_cfg) obs_err_cfg++;
        if (m_axis_up_tvalid && m_axis_up_tready) obs_beats++;

        up_hs = feed && s_axis_tvalid && m_axis_up_tready;
        r_hs  = ((ph == P_FEED) || (ph == P_DRAIN)) && rslt_tvalid && rslt_tready;
        nph = ph;
        exp_err_cfg = 0;
        exp_err_to  = 0;
        if (abort && ph != P_IDLE) begin
            nph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE: if (start && !abort) begin
                    if (cfg_len_v != 0 && cfg_num_v != 0) begin
                        m_len = cfg_len_v; m_num = cfg_num_v;
                        m_beats = 0; m_rslt = 0;
                        nph = P_FEED;
                    end else begin
                        exp_err_cfg = 1;
                    end
                end
                P_FEED: begin
                    quiet_since = cyc;
                    if (r_hs) m_rslt++;
                    if (up_hs) begin
                        m_beats++;
                        if (m_beats == m_len * m_num) nph = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (r_hs) begin
                        m_rslt++;
                        quiet_since = cyc;
                    end
                    if (m_rslt >= m_num * PE) nph = P_DONE;
`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
                    else if (!r_hs && (cyc - quiet_since == TO - 1)) begin
                        nph = P_IDLE;
                        exp_err_to = 1;
                    end
`endif
                end
                P_DONE: nph = P_IDLE;
                default: nph = P_IDLE;
            endcase
        end
        ph = nph;
        exp_busy = (ph == P_FEED) || (ph == P_DRAIN);
        exp_done = (ph == P_DONE);
        cyc++;
    endtask

    task automatic start_run(input int len, input int num);
        cfg_len_v = len;
        cfg_num_v = num;
        start_req = 1'b1;
        step();
    endtask

    // Bounded wait for the run to finish; a stuck DUT shows up as busy=1.
    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (ph == P_IDLE) break;
        end
        step();
        check(tag, busy, 1'b0);
    endtask

    task automatic run_one(input string tag, input int len, input int num, input int exp_dones);
        int d0, b0;
        d0 = obs_done;
        b0 = obs_beats;
        start_run(len, num);
        wait_idle({tag, "_idle"}, 2000);
        check({tag, "_dones"}, obs_done - d0, exp_dones);
        check({tag, "_beats"}, obs_beats - b0, len * num);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0, e0;
        cyc = 0; quiet_since = 0;
        rst = 1'b1; start = 0; abort = 0; cfg_vec_len = '0; cfg_num_vec = '0;
        s_axis_tdata = '0; s_axis_tvalid = 0; m_axis_up_tready = 0;
        rslt_tvalid = 0; rslt_tready = 0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Nominal: 3x2 beats, tready always high.
        p_valid = 100; p_ready = 100; p_rslt = 60; p_rready = 100;
        run_one("nominal", 3, 2, 1);

        // Backpressure: up tready toggles every cycle.
        tog_ready = 1'b1;
        run_one("backpressure", 3, 2, 1);
        tog_ready = 1'b0;

        // Config error: zero vector length.
        e0 = obs_err_cfg;
        cfg_len_v = 0; cfg_num_v = 2; start_req = 1'b1;
        repeat (3) step();
        check("cfg_err_pulses", obs_err_cfg - e0, 1);
        check("cfg_err_busy", busy, 1'b0);

        // Abort after two beats, then a fresh 2x1 run.
        d0 = obs_done;
        start_run(3, 2);
        for (int i = 0; i < 50 && m_beats < 2; i++) step();
        abort_req = 1'b1;
        step();
        step();
        check("abort_busy", busy, 1'b0);
        repeat (4) step();
        check("abort_dones", obs_done - d0, 0);
        run_one("fresh", 2, 1, 1);

        // Early results: all results arrive while data trickles in.
        p_valid = 15; p_rslt = 100; p_rready = 100;
        run_one("early", 3, 2, 1);

        // Asynchronous reset in the middle of a run.
        p_valid = 100; p_ready = 100; p_rslt = 30; p_rready = 80;
        start_run(4, 3);
        repeat (5) step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_tready", s_axis_tready, 1'b0);
        check("arst_tvalid", m_axis_up_tvalid, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();

`ifdef LPE_SEQ_RSLT_TIMEOUT_EN
        // Only 7 of 8 results: watchdog ends the run.
        begin
            int t0, dd;
            t0 = obs_err_to;
            dd = obs_done;
            rslt_cap = 7; p_rslt = 100; p_rready = 100;
            start_run(3, 2);
            wait_idle("timeout_idle", 200);
            check("timeout_pulses", obs_err_to - t0, 1);
            check("timeout_dones", obs_done - dd, 0);
            rslt_cap = 1 << 30;
        end
`endif

        // Randomized runs with occasional aborts and odd start requests.
        for (int r = 0; r < 30; r++) begin
            int len, num, sel, abort_at;
            len = $urandom_range(5, 1);
            num = $urandom_range(4, 1);
            p_valid  = $urandom_range(100, 30);
            p_ready  = $urandom_range(100, 30);
            p_rslt   = $urandom_range(100, 20);
            p_rready = $urandom_range(100, 50);
            tog_ready = ($urandom_range(3) == 0);
            sel = $urandom_range(9);
            if (sel == 0) begin
                cfg_len_v = $urandom_range(1) ? 0 : len;
                cfg_num_v = (cfg_len_v == 0) ? num : 0;
                start_req = 1'b1;
                repeat (2) step();
            end else if (sel == 1) begin
                cfg_len_v = len; cfg_num_v = num;
                start_req = 1'b1; abort_req = 1'b1;
                repeat (2) step();
                check("start_abort_busy", busy, 1'b0);
            end else begin
                abort_at = (sel == 2) ? $urandom_range(30) : -1;
                start_run(len, num);
                for (int i = 0; i < 2000; i++) begin
                    if (i == abort_at) abort_req = 1'b1;
                    step();
                    if (ph == P_IDLE) break;
                end
                step();
                check("rand_idle", busy, 1'b0);
            end
        end
        tog_ready = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
